// File: rtl/mm_tile_pkg.sv
// Shared types for the operand-tile fill and result-tile drain engines.
package mm_tile_pkg;

  typedef logic [15:0] tile_idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } fill_state_t;

endpackage

// File: rtl/tile_idx_walker.sv
// Row/column index walker over a tile; column-fastest or row-fastest order.
// 'last' flags that the current index is the final element of the tile.
module tile_idx_walker
  import mm_tile_pkg::*;
#(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  input  logic          col_major,
  input  tile_idx_t     rows_m1,
  input  tile_idx_t     cols_m1,
  output tile_idx_t     row,
  output logic [CW-1:0] col_lo,
  output logic          last
);

  tile_idx_t row_q, row_d;
  tile_idx_t col_q, col_d;
  logic      row_end;
  logic      col_end;

  assign row_end = (row_q == rows_m1);
  assign col_end = (col_q == cols_m1);
  assign last    = row_end && col_end;
  assign row     = row_q;
  assign col_lo  = col_q[CW-1:0];

  // The owner leaves the walk after the final index, so no wrap is needed there.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
      if (col_major) begin
        if (row_end) begin
          row_d = '0;
          col_d = col_q + 16'd1;
        end else begin
          row_d = row_q + 16'd1;
        end
      end else begin
        if (col_end) begin
          col_d = '0;
          row_d = row_q + 16'd1;
        end else begin
          col_d = col_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/tile_fill.sv
// Fills an operand tile into row-banked BRAMs from a ready/valid element stream.
// Bank = tile row, address = {bankset_sel, col}; writes are registered one cycle after acceptance.
module tile_fill
  import mm_tile_pkg::*;
#(
  parameter int W  = 8,
  parameter int T  = 16,
  parameter int AW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic [15:0]            tile_rows,
  input  logic [15:0]            tile_cols,
  input  logic                   bankset_sel,
  input  logic                   col_major,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic                   in_last,
  output logic [T-1:0]           b_we,
  output logic [T-1:0][AW-1:0]   b_addr,
  output logic [T-1:0][W-1:0]    b_din
);

  localparam int MAX_COLS = 2 ** (AW - 1);

  fill_state_t state_q, state_d;
  tile_idx_t   rows_m1_q, rows_m1_d;
  tile_idx_t   cols_m1_q, cols_m1_d;
  logic        sel_q, sel_d;
  logic        col_major_q, col_major_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [T-1:0]         b_we_q, b_we_d;
  logic [T-1:0][AW-1:0] b_addr_q, b_addr_d;
  logic [T-1:0][W-1:0]  b_din_q, b_din_d;

  logic          accept;
  logic          walk_clear;
  logic          last_idx;
  tile_idx_t     row_idx;
  logic [AW-2:0] col_addr;
  logic [T-1:0]  hit;
  logic          shape_zero;
  logic          shape_big;

  assign busy     = (state_q == S_FILL);
  assign in_ready = busy;
  assign accept   = in_valid && busy;
  assign done     = done_q;
  assign err      = err_q;
  assign b_we     = b_we_q;
  assign b_addr   = b_addr_q;
  assign b_din    = b_din_q;

  assign shape_zero = (tile_rows == 16'd0) || (tile_cols == 16'd0);
  assign shape_big  = (tile_rows > tile_idx_t'(T)) || (tile_cols > tile_idx_t'(MAX_COLS));

  tile_idx_walker #(
    .CW (AW - 1)
  ) u_walker (
    .clk       (clk),
    .rst       (rst),
    .clear     (walk_clear),
    .step      (accept),
    .col_major (col_major_q),
    .rows_m1   (rows_m1_q),
    .cols_m1   (cols_m1_q),
    .row       (row_idx),
    .col_lo    (col_addr),
    .last      (last_idx)
  );

  // done trails the S_DONE state by one cycle so it lands after the final write.
  always_comb begin
    state_d     = state_q;
    rows_m1_d   = rows_m1_q;
    cols_m1_d   = cols_m1_q;
    sel_d       = sel_q;
    col_major_d = col_major_q;
    err_d       = err_q;
    walk_clear  = 1'b0;
    done_d      = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = shape_big;
          if (shape_zero || shape_big) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_FILL;
            rows_m1_d   = tile_rows - 16'd1;
            cols_m1_d   = tile_cols - 16'd1;
            sel_d       = bankset_sel;
            col_major_d = col_major;
            walk_clear  = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (accept) begin
          if (last_idx != in_last) err_d = 1'b1;
          if (last_idx) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < T; gi++) begin : g_bank
    assign hit[gi] = accept && (row_idx == tile_idx_t'(gi));
  end

  always_comb begin
    b_we_d   = hit;
    b_addr_d = b_addr_q;
    b_din_d  = b_din_q;
    for (int i = 0; i < T; i++) begin
      if (hit[i]) begin
        b_addr_d[i] = {sel_q, col_addr};
        b_din_d[i]  = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_m1_q   <= '0;
      cols_m1_q   <= '0;
      sel_q       <= 1'b0;
      col_major_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      b_we_q      <= '0;
      b_addr_q    <= '0;
      b_din_q     <= '0;
    end else begin
      state_q     <= state_d;
      rows_m1_q   <= rows_m1_d;
      cols_m1_q   <= cols_m1_d;
      sel_q       <= sel_d;
      col_major_q <= col_major_d;
      err_q       <= err_d;
      done_q      <= done_d;
      b_we_q      <= b_we_d;
      b_addr_q    <= b_addr_d;
      b_din_q     <= b_din_d;
    end
  end

endmodule
